// File: rtl/accum_counter_pkg.sv
// rtl/accum_counter_pkg.sv - shared mode constants and packing helpers for the counter bank
package accum_counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Low bit of channel idx inside a flat bus of width-bit slices.
    function automatic int lane_lo(input int idx, input int width);
        return idx * width;
    endfunction

    // Width able to hold the sum of nch totals of tot_w bits, never below tot_w+1.
    function automatic int sum_width(input int nch, input int tot_w);
        return tot_w + ((nch > 1) ? $clog2(nch) : 1);
    endfunction

endpackage

// File: rtl/accum_counter_lane.sv
// rtl/accum_counter_lane.sv - one accumulating channel: total, sticky overflow, threshold hit
module accum_counter_lane
    import accum_counter_pkg::*;
#(
    parameter int AMT_W    = 4,
    parameter int TOT_W    = 8,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic [AMT_W-1:0] amt,
    input  logic             clr,
    input  logic [TOT_W-1:0] thresh,
    output logic [TOT_W-1:0] tot,
    output logic             ovf,
    output logic             hit
);

    logic [TOT_W:0]   sum_ext;
    logic             carry;
    logic [TOT_W-1:0] next_tot;
    logic             do_inc;

    always_comb begin
        sum_ext = {1'b0, tot} + {{(TOT_W + 1 - AMT_W){1'b0}}, amt};
        carry   = sum_ext[TOT_W];
        if (carry && (SATURATE == MODE_SAT)) begin
            next_tot = '1;
        end else begin
            next_tot = sum_ext[TOT_W-1:0];
        end
        // A zero amount must not touch ovf or fire hit, so it is treated as hold.
        do_inc = inc && (amt != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tot <= '0;
            ovf <= 1'b0;
            hit <= 1'b0;
        end else if (clr) begin
            tot <= '0;
            ovf <= 1'b0;
            hit <= 1'b0;
        end else if (do_inc) begin
            tot <= next_tot;
            ovf <= ovf | carry;
            hit <= (tot < thresh) && (next_tot >= thresh);
        end else begin
            hit <= 1'b0;
        end
    end

endmodule

// File: rtl/accum_counter_bank.sv
// rtl/accum_counter_bank.sv - bank of independent accumulating counters with a registered grand total
module accum_counter_bank
    import accum_counter_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int AMT_W    = 4,
    parameter int TOT_W    = 8,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NCH-1:0]                      io_inc,
    input  logic [NCH*AMT_W-1:0]                io_amt,
    input  logic [NCH-1:0]                      io_clr,
    input  logic [TOT_W-1:0]                    io_thresh,
    output logic [NCH*TOT_W-1:0]                io_tot,
    output logic [NCH-1:0]                      io_ovf,
    output logic [NCH-1:0]                      io_hit,
    output logic [sum_width(NCH, TOT_W)-1:0]    io_sum
);

    localparam int SUM_W = sum_width(NCH, TOT_W);

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        accum_counter_lane #(
            .AMT_W    (AMT_W),
            .TOT_W    (TOT_W),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .inc    (io_inc[i]),
            .amt    (io_amt[lane_lo(i, AMT_W) +: AMT_W]),
            .clr    (io_clr[i]),
            .thresh (io_thresh),
            .tot    (io_tot[lane_lo(i, TOT_W) +: TOT_W]),
            .ovf    (io_ovf[i]),
            .hit    (io_hit[i])
        );
    end

    // Sums the registered totals, so io_sum trails io_tot by exactly one edge.
    logic [SUM_W-1:0] sum_next;

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < NCH; i++) begin
            sum_next = sum_next + SUM_W'(io_tot[lane_lo(i, TOT_W) +: TOT_W]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_sum <= '0;
        end else begin
            io_sum <= sum_next;
        end
    end

endmodule
